stage_d_write_buffer: RTL and testbench

Write-back stage for the brainfuck CPU pipeline with a parametrised posted-write buffer between the execute path and data RAM. Writes from INC, DEC and IN are queued with their data pointer, drained to DRAM under a ready/acknowledge handshake, and merged when consecutive writes target the same cell. A forwarding port lets the read stage see queued data before it reaches DRAM. The stage sits after the ALU stage and feeds the DRAM write port.

---
 rtl/stage_d_write_buffer_pkg.sv | 23 ++
 rtl/stage_d_write_buffer_write_fifo.sv | 93 +++++++++
 rtl/stage_d_write_buffer.sv | 76 +++++++
 tb/tb_stage_d_write_buffer.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stage_d_write_buffer_pkg.sv
// Shared opcode constants and decode helpers for the brainfuck CPU pipeline.
// The write-op predicate lives here so the read stage can reuse it.
package stage_d_write_buffer_pkg;

    localparam int OPCODE_MSB = 7;

    // One-hot bit positions of the eight brainfuck operations.
    localparam int OP_INC   = 0;
    localparam int OP_DEC   = 1;
    localparam int OP_LEFT  = 2;
    localparam int OP_RIGHT = 3;
    localparam int OP_IN    = 4;
    localparam int OP_OUT   = 5;
    localparam int OP_LOOP  = 6;
    localparam int OP_END   = 7;

    typedef logic [OPCODE_MSB:0] opcode_t;

    function automatic logic is_write_op(input opcode_t op);
        return op[OP_INC] | op[OP_DEC] | op[OP_IN];
    endfunction

endpackage

// File: rtl/stage_d_write_buffer_write_fifo.sv
// Posted-write queue: storage, pointers, count, youngest-entry coalescing
// and a CAM-style forwarding lookup over the valid entries.
module stage_d_write_buffer_write_fifo #(
    parameter int A_WIDTH = 12,
    parameter int D_WIDTH = 8,
    parameter int DEPTH   = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               write,
    input  logic [A_WIDTH-1:0] wa,
    input  logic [D_WIDTH-1:0] wd,
    output logic               coalesce,
    output logic               full,
    output logic               empty,
    output logic               dce,
    output logic [A_WIDTH-1:0] da,
    output logic [D_WIDTH-1:0] dq,
    input  logic               dack,
    input  logic [A_WIDTH-1:0] fa,
    output logic               fhit,
    output logic [D_WIDTH-1:0] fq
);

    localparam int PW = $clog2(DEPTH);

    logic [A_WIDTH-1:0] addr_mem [DEPTH];
    logic [D_WIDTH-1:0] data_mem [DEPTH];

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] last;
    logic [PW-1:0] idx;
    logic [PW:0]   count;
    logic          push;
    logic          pop;

    assign last  = wr_ptr - PW'(1);
    assign full  = count == (PW+1)'(DEPTH);
    assign empty = count == '0;

    // The youngest entry is only touched once it cannot be the draining head.
    assign coalesce = write
                    & (count >= (PW+1)'(2))
                    & (addr_mem[last] == wa);

    assign push = write & ~coalesce & ~full;
    assign pop  = ~empty & dack;

    assign dce = ~empty;
    assign da  = empty ? '0 : addr_mem[rd_ptr];
    assign dq  = empty ? '0 : data_mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            count <= count
                   + {{PW{1'b0}}, push}
                   - {{PW{1'b0}}, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr] <= wa;
            data_mem[wr_ptr] <= wd;
        end else if (coalesce) begin
            data_mem[last] <= wd;
        end
    end

    // Scan oldest to youngest so the last match left standing is the youngest.
    always_comb begin
        fhit = 1'b0;
        fq   = '0;
        idx  = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr + PW'(k);
            if (((PW+1)'(k) < count) && (addr_mem[idx] == fa)) begin
                fhit = 1'b1;
                fq   = data_mem[idx];
            end
        end
    end

endmodule

// File: rtl/stage_d_write_buffer.sv
// Write-back stage: opcode pass-through, stall generation and a posted-write
// buffer that drains to the DRAM write port.
module stage_d_write_buffer
    import stage_d_write_buffer_pkg::*;
#(
    parameter int A_WIDTH = 12,
    parameter int D_WIDTH = 8,
    parameter int DEPTH   = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [OPCODE_MSB:0] operation_in,
    input  logic [D_WIDTH-1:0]  a_in,
    input  logic [A_WIDTH-1:0]  dp,
    input  logic                drdy_in,
    input  logic                ack_in,
    output logic                ack,
    output logic [OPCODE_MSB:0] operation,
    output logic                drdy,
    output logic                dce,
    output logic [A_WIDTH-1:0]  da,
    output logic [D_WIDTH-1:0]  dq,
    input  logic                dack,
    input  logic [A_WIDTH-1:0]  fa,
    output logic                fhit,
    output logic [D_WIDTH-1:0]  fq,
    output logic                full,
    output logic                empty
);

    logic write_op;
    logic coalesce;
    logic stall;

    assign write_op = is_write_op(operation_in);

    // Full is the registered occupancy, so dack never reaches ack.
    assign stall = write_op & full & ~coalesce;
    assign ack   = ack_in & ~stall;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            operation <= '0;
            drdy      <= 1'b0;
        end else if (stall) begin
            operation <= '0;
            drdy      <= 1'b0;
        end else begin
            operation <= operation_in;
            drdy      <= drdy_in;
        end
    end

    stage_d_write_buffer_write_fifo #(
        .A_WIDTH (A_WIDTH),
        .D_WIDTH (D_WIDTH),
        .DEPTH   (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .write    (write_op),
        .wa       (dp),
        .wd       (a_in),
        .coalesce (coalesce),
        .full     (full),
        .empty    (empty),
        .dce      (dce),
        .da       (da),
        .dq       (dq),
        .dack     (dack),
        .fa       (fa),
        .fhit     (fhit),
        .fq       (fq)
    );

endmodule

// File: tb/tb_stage_d_write_buffer.sv
// Directed bench for stage_d_write_buffer: a vector table for pass-through
// and drain, plus hand sequences for coalesce, stall, forwarding, reset, wrap.
module tb_stage_d_write_buffer;

    localparam logic [7:0] O_NOP   = 8'h00;
    localparam logic [7:0] O_INC   = 8'h01;
    localparam logic [7:0] O_DEC   = 8'h02;
    localparam logic [7:0] O_RIGHT = 8'h08;
    localparam logic [7:0] O_IN    = 8'h10;
    localparam logic [7:0] O_OUT   = 8'h20;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  operation_in;
    logic [7:0]  a_in;
    logic [11:0] dp;
    logic        drdy_in;
    logic        ack_in;
    logic        ack;
    logic [7:0]  operation;
    logic        drdy;
    logic        dce;
    logic [11:0] da;
    logic [7:0]  dq;
    logic        dack;
    logic [11:0] fa;
    logic        fhit;
    logic [7:0]  fq;
    logic        full;
    logic        empty;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [11:0] a;
        logic [7:0]  d;
    } wr_t;

    wr_t log_q[$];

    typedef struct {
        logic [7:0]  op;
        logic [7:0]  a;
        logic [11:0] dp;
        logic        drdy_in;
        logic        ack_in;
        logic        dack;
        logic [11:0] fa;
        logic [7:0]  e_op;
        logic        e_drdy;
        logic        e_ack;
        logic        e_dce;
        logic [11:0] e_da;
        logic [7:0]  e_dq;
        logic        e_fhit;
        logic [7:0]  e_fq;
        logic        e_empty;
    } vec_t;

    vec_t vt[8];

    always #5 clk = ~clk;

    stage_d_write_buffer #(
        .A_WIDTH (12),
        .D_WIDTH (8),
        .DEPTH   (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .operation_in (operation_in),
        .a_in         (a_in),
        .dp           (dp),
        .drdy_in      (drdy_in),
        .ack_in       (ack_in),
        .ack          (ack),
        .operation    (operation),
        .drdy         (drdy),
        .dce          (dce),
        .da           (da),
        .dq           (dq),
        .dack         (dack),
        .fa           (fa),
        .fhit         (fhit),
        .fq           (fq),
        .full         (full),
        .empty        (empty)
    );

    // Inputs only change #1 after a rising edge, so the negedge view is
    // exactly what the next rising edge will retire.
    always @(negedge clk) begin
        if (!reset && dce && dack)
            log_q.push_back({da, dq});
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [7:0] op, input logic [7:0] a,
                          input logic [11:0] p, input logic dr);
        operation_in = op;
        a_in         = a;
        dp           = p;
        drdy_in      = dr;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        set_in(O_NOP, 8'h00, 12'h000, 1'b0);
        dack = 1'b0;
        tick();
        reset = 1'b0;
        log_q.delete();
    endtask

    task automatic chk_log(input string nm, input int idx,
                           input logic [11:0] a, input logic [7:0] d);
        if (idx < log_q.size()) begin
            chk({nm, "_addr"}, 32'(log_q[idx].a), 32'(a));
            chk({nm, "_data"}, 32'(log_q[idx].d), 32'(d));
        end else begin
            chk({nm, "_present"}, 32'(0), 32'(1));
        end
    endtask

    initial begin
        reset  = 1'b1;
        ack_in = 1'b1;
        dack   = 1'b0;
        fa     = 12'h000;
        set_in(O_IN, 8'h11, 12'h001, 1'b1);
        #1;
        chk("rst_operation", 32'(operation), 32'h0);
        chk("rst_drdy", 32'(drdy), 32'h0);
        chk("rst_dce", 32'(dce), 32'h0);
        chk("rst_da", 32'(da), 32'h0);
        chk("rst_dq", 32'(dq), 32'h0);
        chk("rst_empty", 32'(empty), 32'h1);
        chk("rst_full", 32'(full), 32'h0);
        chk("rst_fhit", 32'(fhit), 32'h0);
        chk("rst_fq", 32'(fq), 32'h0);
        do_reset();

        // Pass-through, drain and ack gating.
        vt[0] = '{O_IN,    8'h33, 12'h100, 1'b1, 1'b1, 1'b0, 12'h100,
                  O_NOP,   1'b0, 1'b1, 1'b0, 12'h000, 8'h00, 1'b0, 8'h00, 1'b1};
        vt[1] = '{O_RIGHT, 8'h00, 12'h101, 1'b0, 1'b1, 1'b0, 12'h100,
                  O_IN,    1'b1, 1'b1, 1'b1, 12'h100, 8'h33, 1'b1, 8'h33, 1'b0};
        vt[2] = '{O_DEC,   8'h32, 12'h101, 1'b1, 1'b1, 1'b1, 12'h101,
                  O_RIGHT, 1'b0, 1'b1, 1'b1, 12'h100, 8'h33, 1'b0, 8'h00, 1'b0};
        vt[3] = '{O_NOP,   8'h00, 12'h000, 1'b0, 1'b1, 1'b1, 12'h101,
                  O_DEC,   1'b1, 1'b1, 1'b1, 12'h101, 8'h32, 1'b1, 8'h32, 1'b0};
        vt[4] = '{O_OUT,   8'h00, 12'h000, 1'b1, 1'b1, 1'b1, 12'h101,
                  O_NOP,   1'b0, 1'b1, 1'b0, 12'h000, 8'h00, 1'b0, 8'h00, 1'b1};
        vt[5] = '{O_INC,   8'h05, 12'h007, 1'b0, 1'b0, 1'b0, 12'h007,
                  O_OUT,   1'b1, 1'b0, 1'b0, 12'h000, 8'h00, 1'b0, 8'h00, 1'b1};
        vt[6] = '{O_NOP,   8'h00, 12'h000, 1'b0, 1'b1, 1'b1, 12'h007,
                  O_INC,   1'b0, 1'b1, 1'b1, 12'h007, 8'h05, 1'b1, 8'h05, 1'b0};
        vt[7] = '{O_NOP,   8'h00, 12'h000, 1'b0, 1'b1, 1'b0, 12'h007,
                  O_NOP,   1'b0, 1'b1, 1'b0, 12'h000, 8'h00, 1'b0, 8'h00, 1'b1};

        for (int i = 0; i < 8; i++) begin
            set_in(vt[i].op, vt[i].a, vt[i].dp, vt[i].drdy_in);
            ack_in = vt[i].ack_in;
            dack   = vt[i].dack;
            fa     = vt[i].fa;
            @(negedge clk);
            chk($sformatf("v%0d_operation", i), 32'(operation), 32'(vt[i].e_op));
            chk($sformatf("v%0d_drdy", i), 32'(drdy), 32'(vt[i].e_drdy));
            chk($sformatf("v%0d_ack", i), 32'(ack), 32'(vt[i].e_ack));
            chk($sformatf("v%0d_dce", i), 32'(dce), 32'(vt[i].e_dce));
            chk($sformatf("v%0d_da", i), 32'(da), 32'(vt[i].e_da));
            chk($sformatf("v%0d_dq", i), 32'(dq), 32'(vt[i].e_dq));
            chk($sformatf("v%0d_fhit", i), 32'(fhit), 32'(vt[i].e_fhit));
            chk($sformatf("v%0d_fq", i), 32'(fq), 32'(vt[i].e_fq));
            chk($sformatf("v%0d_empty", i), 32'(empty), 32'(vt[i].e_empty));
            tick();
        end
        ack_in = 1'b1;
        chk("pt_log_size", 32'(log_q.size()), 32'd3);
        chk_log("pt_log0", 0, 12'h100, 8'h33);
        chk_log("pt_log1", 1, 12'h101, 8'h32);
        chk_log("pt_log2", 2, 12'h007, 8'h05);

        // Coalesce into the youngest non-head entry.
        do_reset();
        set_in(O_INC, 8'h01, 12'h005, 1'b1); tick();
        set_in(O_INC, 8'h02, 12'h006, 1'b1); tick();
        set_in(O_DEC, 8'h03, 12'h006, 1'b1); tick();
        set_in(O_IN,  8'h04, 12'h006, 1'b1);
        @(negedge clk);
        chk("co_ack", 32'(ack), 32'h1);
        tick();
        set_in(O_NOP, 8'h00, 12'h000, 1'b0);
        fa = 12'h006;
        @(negedge clk);
        chk("co_fhit6", 32'(fhit), 32'h1);
        chk("co_fq6", 32'(fq), 32'h04);
        chk("co_full", 32'(full), 32'h0);
        fa = 12'h005;
        #1;
        chk("co_fq5", 32'(fq), 32'h01);
        tick();
        dack = 1'b1;
        repeat (4) tick();
        chk("co_log_size", 32'(log_q.size()), 32'd2);
        chk_log("co_log0", 0, 12'h005, 8'h01);
        chk_log("co_log1", 1, 12'h006, 8'h04);
        chk("co_empty", 32'(empty), 32'h1);

        // Full stall, one dack pulse, then acceptance.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            set_in(O_IN, 8'hA0 + 8'(i), 12'(i), 1'b1);
            tick();
        end
        chk("st_full4", 32'(full), 32'h1);
        set_in(O_IN, 8'hA4, 12'h004, 1'b1);
        @(negedge clk);
        chk("st_ack_stall", 32'(ack), 32'h0);
        tick();
        chk("st_bubble_op", 32'(operation), 32'h0);
        chk("st_bubble_drdy", 32'(drdy), 32'h0);
        dack = 1'b1;
        @(negedge clk);
        chk("st_ack_pulse", 32'(ack), 32'h0);
        tick();
        dack = 1'b0;
        @(negedge clk);
        chk("st_full_after", 32'(full), 32'h0);
        chk("st_ack_accept", 32'(ack), 32'h1);
        tick();
        chk("st_op_accept", 32'(operation), 32'(O_IN));
        chk("st_full_again", 32'(full), 32'h1);
        set_in(O_NOP, 8'h00, 12'h000, 1'b0);
        dack = 1'b1;
        repeat (6) tick();
        chk("st_log_size", 32'(log_q.size()), 32'd5);
        for (int i = 0; i < 5; i++)
            chk_log($sformatf("st_log%0d", i), i, 12'(i), 8'hA0 + 8'(i));

        // Forwarding with a non-adjacent rewrite, then reset mid-drain.
        do_reset();
        set_in(O_IN,  8'h7F, 12'h010, 1'b1); tick();
        set_in(O_INC, 8'h55, 12'h011, 1'b1); tick();
        set_in(O_DEC, 8'h80, 12'h010, 1'b1); tick();
        set_in(O_NOP, 8'h00, 12'h000, 1'b0);
        fa = 12'h010;
        #1;
        chk("fw_hit10", 32'(fhit), 32'h1);
        chk("fw_fq10", 32'(fq), 32'h80);
        fa = 12'h011;
        #1;
        chk("fw_fq11", 32'(fq), 32'h55);
        fa = 12'h012;
        #1;
        chk("fw_hit12", 32'(fhit), 32'h0);
        chk("fw_fq12", 32'(fq), 32'h00);
        fa = 12'h010;
        chk("mr_dce_before", 32'(dce), 32'h1);
        reset = 1'b1;
        #1;
        chk("mr_dce", 32'(dce), 32'h0);
        chk("mr_empty", 32'(empty), 32'h1);
        chk("mr_fhit", 32'(fhit), 32'h0);
        chk("mr_operation", 32'(operation), 32'h0);
        tick();
        reset = 1'b0;
        dack  = 1'b1;
        repeat (5) tick();
        chk("mr_log_size", 32'(log_q.size()), 32'd0);
        chk("mr_empty_end", 32'(empty), 32'h1);

        // Back-to-back writes with dack held: pointers wrap, head is always
        // the write from the previous cycle.
        do_reset();
        dack = 1'b1;
        for (int i = 0; i < 20; i++) begin
            set_in(O_IN, 8'(i * 7 + 3), 12'(i), 1'b1);
            @(negedge clk);
            if (i > 0) begin
                chk($sformatf("wr_da%0d", i), 32'(da), 32'(i - 1));
                chk($sformatf("wr_full%0d", i), 32'(full), 32'h0);
            end
            tick();
        end
        set_in(O_NOP, 8'h00, 12'h000, 1'b0);
        repeat (2) tick();
        chk("wr_log_size", 32'(log_q.size()), 32'd20);
        for (int i = 0; i < 20; i++)
            chk_log($sformatf("wr_log%0d", i), i, 12'(i), 8'(i * 7 + 3));
        chk("wr_empty", 32'(empty), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
